// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command sequencer: opcodes,
// sequencer state encoding and the queued command record.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_ROL = 4'b1100;
    localparam logic [3:0] OP_ROR = 4'b1101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_GUARD = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } alu_cmd_t;

    localparam int CMD_W = $bits(alu_cmd_t);

    function automatic logic is_div_by_zero(input logic [3:0] op, input logic [15:0] b);
        return (op == OP_DIV) && (b == 16'h0000);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry synchronous command FIFO with full/empty flags.
// Writes while full and reads while empty are ignored.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  alu_cmd_t wdata,
    output alu_cmd_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    alu_cmd_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues them one at a time with a start pulse and
// returns each result (or a timeout error) over a valid/ready port.
//
// state | meaning
// IDLE  | waiting for a queued command; pops it into the alu_* registers
// ISSUE | alu_start high for this single cycle; timeout counter cleared
// GUARD | alu_valid ignored so a stale level is not mistaken for the result
// WAIT  | waiting for alu_valid or the timeout
// HOLD  | result presented; waits for res_ready
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic        alu_start,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_z_low,
    input  logic [15:0] alu_z_high,
    input  logic        alu_valid,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_op,
    output logic [15:0] res_z_low,
    output logic [15:0] res_z_high,
    output logic        res_err,
    output logic        res_dz
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

    seq_state_t     state;
    logic [TW-1:0]  tmo_cnt;
    alu_cmd_t       head;
    alu_cmd_t       wr_cmd;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;

    assign wr_cmd    = '{op: cmd_op, a: cmd_a, b: cmd_b};
    assign cmd_ready = !fifo_full;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (fifo_pop),
        .wdata (wr_cmd),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            tmo_cnt    <= '0;
            alu_start  <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            res_valid  <= 1'b0;
            res_op     <= '0;
            res_z_low  <= '0;
            res_z_high <= '0;
            res_err    <= 1'b0;
            res_dz     <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Start is registered on the pop so it is high exactly during ISSUE.
                    if (!fifo_empty) begin
                        alu_op    <= head.op;
                        alu_a     <= head.a;
                        alu_b     <= head.b;
                        alu_start <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= ST_GUARD;
                end
                ST_GUARD: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu_valid) begin
                        res_z_low  <= alu_z_low;
                        res_z_high <= alu_z_high;
                        res_err    <= 1'b0;
                        res_dz     <= is_div_by_zero(alu_op, alu_b);
                        res_op     <= alu_op;
                        res_valid  <= 1'b1;
                        state      <= ST_HOLD;
                    end else if (tmo_cnt == TMO_LIMIT) begin
                        res_z_low  <= '0;
                        res_z_high <= '0;
                        res_err    <= 1'b1;
                        res_dz     <= is_div_by_zero(alu_op, alu_b);
                        res_op     <= alu_op;
                        res_valid  <= 1'b1;
                        state      <= ST_HOLD;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a simple latency-programmable ALU model.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic        alu_start;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_z_low = '0;
    logic [15:0] alu_z_high = '0;
    logic        alu_valid = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [3:0]  res_op;
    logic [15:0] res_z_low;
    logic [15:0] res_z_high;
    logic        res_err;
    logic        res_dz;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int start_cyc = 0;
    int n_starts = 0;
    int alu_lat = 2;
    int m_rem = 0;
    logic [31:0] m_z = '0;

    alu_cmd_sequencer #(.DEPTH(4), .TIMEOUT(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_z_low  (alu_z_low),
        .alu_z_high (alu_z_high),
        .alu_valid  (alu_valid),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_op     (res_op),
        .res_z_low  (res_z_low),
        .res_z_high (res_z_high),
        .res_err    (res_err),
        .res_dz     (res_dz)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        case (op)
            OP_ADD: return {16'h0000, 16'(a + b)};
            OP_SUB: return {16'h0000, 16'(a - b)};
            OP_MUL: begin
                p = $signed(a) * $signed(b);
                return p;
            end
            OP_DIV: begin
                if (b == 16'h0000) return {a, 16'hFFFF};
                return {16'(a % b), 16'(a / b)};
            end
            OP_AND: return {16'h0000, a & b};
            default: return 32'h0;
        endcase
    endfunction

    // ALU model: result valid alu_lat cycles after the start cycle, held until the next start.
    // alu_lat == 0 means the ALU never answers.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (alu_start) begin
            start_cyc <= cyc;
            n_starts  <= n_starts + 1;
            alu_valid <= 1'b0;
            m_z       <= alu_ref(alu_op, alu_a, alu_b);
            m_rem     <= (alu_lat == 0) ? 0 : alu_lat - 1;
        end else if (m_rem == 1) begin
            alu_valid  <= 1'b1;
            alu_z_low  <= m_z[15:0];
            alu_z_high <= m_z[31:16];
            m_rem      <= 0;
        end else if (m_rem != 0) begin
            m_rem <= m_rem - 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        chk("cmd_ready_before_push", cmd_ready, 1);
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input int max_cyc, output int lat);
        int k;
        k = 0;
        while (!res_valid && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk("res_valid_within_bound", res_valid, 1);
        lat = cyc - start_cyc;
    endtask

    task automatic accept();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_drops_after_accept", res_valid, 0);
    endtask

    logic [3:0]  exp_op [5] = '{OP_SUB, OP_MUL, OP_DIV, OP_ADD, OP_AND};
    logic [15:0] exp_lo [5] = '{16'h00C8, 16'hB9B0, 16'h0021, 16'h8000, 16'h3030};
    logic [15:0] exp_hi [5] = '{16'h0000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000};

    initial begin
        int lat;
        int starts0;
        logic [38:0] snap;
        logic seen_rv;
        logic seen_av;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_alu_start", alu_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_res_dz", res_dz, 0);
        chk("rst_alu_regs", {alu_op, alu_a, alu_b}, 0);
        chk("rst_res_regs", {res_op, res_z_low, res_z_high}, 0);

        // ADD 100 + 25, start two edges after acceptance
        alu_lat = 2;
        push(OP_ADD, 16'd100, 16'd25);
        chk("add_no_start_yet", alu_start, 0);
        @(negedge clk);
        chk("add_start_pulse", alu_start, 1);
        chk("add_alu_operands", {alu_op, alu_a, alu_b}, {OP_ADD, 16'd100, 16'd25});
        @(negedge clk);
        chk("add_start_single_cycle", alu_start, 0);
        wait_res(20, lat);
        chk("add_latency", lat, 3);
        chk("add_z_low", res_z_low, 16'h007D);
        chk("add_z_high", res_z_high, 16'h0000);
        chk("add_err", res_err, 0);
        chk("add_dz", res_dz, 0);
        chk("add_op", res_op, OP_ADD);
        accept();

        // Five back-to-back commands with results held off
        starts0 = n_starts;
        push(OP_SUB, 16'd250, 16'd50);
        push(OP_MUL, 16'hFF6A, 16'd120);
        push(OP_DIV, 16'd100, 16'd3);
        push(OP_ADD, 16'h7FFF, 16'h0001);
        push(OP_AND, 16'hF0F0, 16'h3C3C);
        chk("fifo_full_cmd_ready", cmd_ready, 0);

        // Backpressure: result must stay put, nothing else issued
        wait_res(20, lat);
        snap = {res_valid, res_op, res_z_low, res_z_high, res_err, res_dz};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_res_stable", {res_valid, res_op, res_z_low, res_z_high, res_err, res_dz}, snap);
        end
        chk("bp_one_start_only", n_starts - starts0, 1);
        chk("bp_fifo_still_full", cmd_ready, 0);

        for (int i = 0; i < 5; i++) begin
            wait_res(20, lat);
            chk("seq_op", res_op, exp_op[i]);
            chk("seq_z_low", res_z_low, exp_lo[i]);
            chk("seq_z_high", res_z_high, exp_hi[i]);
            chk("seq_err", res_err, 0);
            chk("seq_dz", res_dz, 0);
            accept();
        end
        chk("seq_start_count", n_starts - starts0, 5);
        chk("seq_cmd_ready_after_drain", cmd_ready, 1);

        // DIV by zero: flagged, words forwarded
        push(OP_DIV, 16'd15, 16'd0);
        wait_res(20, lat);
        chk("dz_flag", res_dz, 1);
        chk("dz_err", res_err, 0);
        chk("dz_op", res_op, OP_DIV);
        chk("dz_z_low", res_z_low, 16'hFFFF);
        chk("dz_z_high", res_z_high, 16'h000F);
        accept();

        // Timeout on MUL, then a queued ADD issues normally
        alu_lat = 0;
        push(OP_MUL, 16'hFF6A, 16'd120);
        push(OP_ADD, 16'd5, 16'd6);
        wait_res(100, lat);
        chk("tmo_latency", lat, 66);
        chk("tmo_err", res_err, 1);
        chk("tmo_op", res_op, OP_MUL);
        chk("tmo_z", {res_z_high, res_z_low}, 0);
        alu_lat = 2;
        accept();
        wait_res(20, lat);
        chk("post_tmo_latency", lat, 3);
        chk("post_tmo_z_low", res_z_low, 16'h000B);
        chk("post_tmo_err", res_err, 0);
        chk("post_tmo_op", res_op, OP_ADD);
        accept();

        // Reset during WAIT; late alu_valid must not produce a result
        alu_lat = 20;
        push(OP_ADD, 16'd7, 16'd8);
        repeat (4) @(negedge clk);
        starts0 = n_starts;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_alu_start", alu_start, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_flags", {res_err, res_dz}, 0);
        chk("mid_rst_alu_regs", {alu_op, alu_a, alu_b}, 0);
        chk("mid_rst_res_regs", {res_op, res_z_low, res_z_high}, 0);
        seen_rv = 1'b0;
        seen_av = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            seen_rv |= res_valid;
            seen_av |= alu_valid;
        end
        chk("late_alu_valid_arrived", seen_av, 1);
        chk("late_alu_valid_ignored", seen_rv, 0);
        chk("no_start_after_rst", n_starts - starts0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front-end that sits directly upstream of the 16-bit ALU. Accepts operation commands over a valid/ready handshake into a small FIFO and issues them one at a time to the ALU as a single-cycle `start` pulse. It waits for the ALU's `valid` and returns each result, in order, over a valid/ready result port. It also flags divide-by-zero commands and ALU operations that time out.

## Interface
- `DEPTH`, 4: command FIFO depth; power of two, ≥2.
- `TIMEOUT`, 64: maximum cycles the block waits for `alu_valid` after a start before aborting.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; one clock, reset is synchronous and active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept a command.
- `cmd_op` in 4: ALU opcode (0000 ADD … 1101 ROR; 0010 MUL, 0011 DIV).
- `cmd_a` in 16: operand A, signed.
- `cmd_b` in 16: operand B, signed.
- `alu_start` out 1: one-cycle start pulse to the ALU.
- `alu_op` out 4: opcode to the ALU, held from start until the result is captured.
- `alu_a` out 16: operand A to the ALU, held over the same interval.
- `alu_b` out 16: operand B to the ALU, held over the same interval.
- `alu_z_low` in 16: ALU result, low word.
- `alu_z_high` in 16: ALU result, high word.
- `alu_valid` in 1: ALU result ready.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_op` out 4: opcode of the returned result.
- `res_z_low` out 16: result, low word.
- `res_z_high` out 16: result, high word.
- `res_err` out 1: 1 = timeout; result words are zero.
- `res_dz` out 1: 1 = DIV command with B == 0.

## Operation
- **FIFO**
  - Push when `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`. No push while full, even in a cycle that also pops.
  - Read/write pointers wrap modulo DEPTH.
  - Count is held in log2(DEPTH)+1 bits.
- **FSM states:** IDLE, ISSUE, GUARD, WAIT, HOLD.
- **IDLE**
  - If the FIFO is non-empty: pop the head into the `alu_op`/`alu_a`/`alu_b` registers and go to ISSUE.
- **ISSUE**
  - `alu_start = 1` for exactly this cycle.
  - Clear the timeout counter.
  - Go to GUARD.
- **GUARD**
  - `alu_valid` is ignored for one cycle, so a stale level from the previous operation is not taken as the new result.
  - Counter increments.
  - Go to WAIT.
- **WAIT**
  - When `alu_valid == 1`: capture `alu_z_low`/`alu_z_high` into the `res_*` registers, set `res_err = 0`, go to HOLD.
  - Otherwise, when the counter reaches TIMEOUT: `res_z_* = 0`, `res_err = 1`, go to HOLD.
  - Otherwise the counter increments.
- **HOLD**
  - `res_valid = 1`.
  - All `res_*` outputs are stable until `res_ready`.
  - On `res_valid && res_ready`, go to IDLE.
- **`res_dz`:** set at capture when `alu_op == 4'b0011 && alu_b == 0`. The ALU result is still forwarded unchanged.
- **`res_op`:** equals the issued `alu_op`.
- **Sign handling:** none. Words pass through untouched.
- **Reset**
  - Outputs: `cmd_ready = 1` after reset (FIFO empty). `alu_start`, `res_valid`, `res_err`, `res_dz` = 0. `alu_op`/`alu_a`/`alu_b` = 0. `res_op`/`res_z_low`/`res_z_high` = 0.
  - Internal: FIFO emptied, state = IDLE.
  - Reset mid-operation discards the in-flight command. An `alu_valid` arriving after reset is ignored.

## Timing
- Command accepted at edge N → head visible at N+1 → IDLE pops at N+1 → `alu_start` high during cycle N+2.
- Earliest capture is 2 cycles after the `alu_start` cycle, when `alu_valid` is already high in WAIT.
- Earliest `res_valid` is the cycle after capture.
- Result accepted at edge M → IDLE at M+1 → next `alu_start` at M+2 at the earliest.
- Throughput: at most one ALU operation in flight. `alu_start` is never asserted outside ISSUE.
- Timeout: `res_err` result appears TIMEOUT+2 cycles after `alu_start`.
- Push and pop in the same cycle are allowed when not full; count is unchanged.

## Structure
- A shared package `alu_pkg` holds:
  - opcode localparams (OP_ADD … OP_ROR);
  - the FSM state encoding;
  - the command struct {op, a, b}.
  - The ALU reuses the opcode constants.
- One sub-module: `alu_cmd_fifo` (parameterised DEPTH × 36-bit synchronous FIFO with full/empty). The FSM and result registers live in the top module.

## Test plan
- ADD 100 + 25, ALU model raises valid 2 cycles after start → `res_z_low = 0x007D`, `res_z_high = 0`, `res_err = 0`, `res_dz = 0`, `res_op = 0000`.
- Five back-to-back commands (SUB 250 − 50, MUL −150 × 120, DIV 100 / 3, …) with DEPTH = 4 and the ALU busy:
  - `cmd_ready = 0` after four are queued;
  - results return in order (0x00C8; 0xB9B0/0xFFFF; 0x0021/0x0001);
  - one `alu_start` per command.
- DIV 15 / 0 → `res_dz = 1`, `res_err = 0`, ALU words forwarded.
- MUL −150 × 120 with the ALU model never raising valid → `res_valid` 66 cycles after start, `res_err = 1`, `res_z = 0`. The next queued command then issues normally.
- Result backpressure: `res_ready = 0` for 10 cycles → `res_*` stable, no `alu_start`, queued commands stay in the FIFO.
- `rst` pulsed during WAIT → next cycle all outputs at reset values, `cmd_ready = 1`. A late `alu_valid` produces no `res_valid`.
